shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
// - Shares one combinational left-rotate core between two requesters (ports 0/1) with valid/ready handshakes.
// - Supports four ops on the single rotator: rotate-left, rotate-right, logical shift-left, logical shift-right.
// - Round-robin grant; one registered result stage with a tag naming the requester it came from.
// - Sits between the ALU issue logic and the writeback mux of the multifunction shifter datapath.
// PARAMETERS
// - DW   8   data width; must be a power of 2, >= 2
// - AW   3   shift-amount width; must equal $clog2(DW)
// PORTS
// - clk         in   1    system clock; all state updates on the rising edge
// - reset       in   1    synchronous, active-high reset
// - req_valid   in   2    per-requester request valid; bit i = requester i
// - req_ready   out  2    per-requester accept; one-hot or zero
// - req_data0   in   DW   requester 0 operand
// - req_amt0    in   AW   requester 0 shift amount
// - req_op0     in   2    requester 0 op: 00 ROL, 01 ROR, 10 SHL, 11 SHR
// - req_data1   in   DW   requester 1 operand
// - req_amt1    in   AW   requester 1 shift amount
// - req_op1     in   2    requester 1 op, same encoding
// - out_valid   out  1    result register holds a valid result
// - out_ready   in   1    downstream accepts the result this cycle
// - out_data    out  DW   result
// - out_tag     out  1    index of the requester that produced out_data
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, out_tag=0, priority pointer=0 (requester 0 wins the first tie).
// - Handshakes: a transfer occurs in a cycle where valid and ready are both 1 at the clock edge.
// - Result stage has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
// - accept = !out_valid || out_ready. req_ready is a combinational function of req_valid, accept and the pointer.
// - Grant when accept=1:
//   - Only one requester is valid: that requester is granted.
//   - Both requesters are valid: the requester named by the pointer is granted.
//   - req_ready[g]=1 only for the granted requester g; req_ready=0 when accept=0 or no request is valid.
// - On a grant: out_data <= result(g), out_tag <= g, out_valid <= 1, pointer <= ~g (the loser of the arbitration gets priority next).
// - Pointer is unchanged when there is no grant.
// - accept=1 with no request valid: out_valid <= 0; out_data and out_tag hold their values.
// - FULL and out_ready=0: all output registers hold; req_ready=0 (backpressure).
// - FULL, out_ready=1 and a request valid: the result drains and a new result loads in the same cycle. Throughput is 1 per cycle.
// - Latency: request accept -> out_valid is 1 cycle (registered), independent of op and amt.
// - Op mapping onto the rotate-left core, with r = rotl(data, k) and k in AW bits:
//   - ROL: k=amt, no mask.
//   - ROR: k=(DW-amt) mod DW, computed as -amt truncated to AW bits; no mask.
//   - SHL: k=amt, result = r & ({DW{1'b1}} << amt).
//   - SHR: k=-amt truncated to AW bits, result = r & ({DW{1'b1}} >> amt).
//   - amt=0 returns data unchanged for every op.
// - Request inputs are sampled only on the cycle of their transfer. A requester must hold data, amt and op stable while its valid=1 and ready=0.
// - Reset asserted mid-operation: any pending result is discarded, out_valid=0 on the next cycle, and req_ready=0 while reset=1.
// STRUCTURE
// - Package shift_pkg holds:
//   - op encoding constants OP_ROL, OP_ROR, OP_SHL, OP_SHR;
//   - the DW/AW defaults;
//   - state constants ST_EMPTY, ST_FULL.
// - One sub-module, rotl_core (DW, AW): purely combinational log2(DW)-stage rotate-left. Stage j rotates the output of stage j-1 by 2^j when amt[j]=1.
// - Top level holds the operand mux, op decode and mask, the round-robin pointer, and the output register.
// TESTING
// - Reset, then requester 0 issues ROL data=8'hB4 amt=3 -> next cycle out_valid=1, out_data=8'hA5, out_tag=0.
// - ROR 8'h81 amt=1 -> 8'hC0; SHL 8'hFF amt=4 -> 8'hF0; SHR 8'hFF amt=4 -> 8'h0F; any op with amt=0 -> data unchanged.
// - Both requesters valid for 4 consecutive cycles with out_ready=1 -> out_tag sequence 0,1,0,1 and one result per cycle.
// - out_ready=0 for 3 cycles while FULL -> out_data/out_tag stable and req_ready=2'b00; out_ready=1 -> drain and load in the same cycle.
// - reset=1 asserted while FULL with both requests valid -> the next cycle has out_valid=0 and req_ready=0; after reset, requester 0 wins the tie.
// - Random op/amt/data sweep across all 4 ops and all amt values, checked against a reference model, with random out_ready -> no lost or duplicated transfers.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and defaults for the two-port shift arbiter: op encoding,
// result-stage states and the default datapath geometry.
package shift_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_ROR = 2'b01,
    OP_SHL = 2'b10,
    OP_SHR = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle for shift_arbiter. The slave side is the arbiter,
// the master side is whoever issues requests and consumes results.
interface shift_arbiter_if
  import shift_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_data0;
  logic [AW-1:0] req_amt0;
  logic [1:0]    req_op0;
  logic [DW-1:0] req_data1;
  logic [AW-1:0] req_amt1;
  logic [1:0]    req_op1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_tag;

  modport master (
    output req_valid, req_data0, req_amt0, req_op0,
    output req_data1, req_amt1, req_op1, out_ready,
    input  req_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  req_valid, req_data0, req_amt0, req_op0,
    input  req_data1, req_amt1, req_op1, out_ready,
    output req_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/rotl_core.sv
// Combinational log2(DW)-stage left rotator; stage j rotates by 2^j when
// amt_i[j] is set.
module rotl_core #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] amt_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] stage;

  always_comb begin
    stage = data_i;
    for (int j = 0; j < AW; j++) begin
      if (amt_i[j]) begin
        stage = (stage << (1 << j)) | (stage >> (DW - (1 << j)));
      end
    end
    data_o = stage;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one rotate-left core through a round-robin grant;
// all four ops are mapped onto the rotator plus an output mask.
//
// state    | meaning
// ST_EMPTY | result register holds nothing, out_valid=0
// ST_FULL  | result register holds a result waiting for out_ready
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  shift_arbiter_if.slave bus
);

  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  state_e        state_q, state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_tag_q, out_tag_d;
  logic          ptr_q, ptr_d;

  logic          accept;
  logic          any_req;
  logic          gnt;
  logic [1:0]    req_ready;
  logic [DW-1:0] sel_data;
  logic [AW-1:0] sel_amt;
  op_e           sel_op;
  logic [AW-1:0] rot_amt;
  logic [DW-1:0] rot_out;
  logic [DW-1:0] mask;
  logic [DW-1:0] result;

  always_comb begin
    any_req = |bus.req_valid;
    accept  = (state_q == ST_EMPTY) || bus.out_ready;
    case (bus.req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ptr_q;
      default: gnt = 1'b0;
    endcase
  end

  always_comb begin
    sel_data = gnt ? bus.req_data1 : bus.req_data0;
    sel_amt  = gnt ? bus.req_amt1  : bus.req_amt0;
    sel_op   = op_e'(gnt ? bus.req_op1 : bus.req_op0);
  end

  // Right-going ops rotate left by the two's complement of amt.
  always_comb begin
    rot_amt = sel_amt;
    mask    = ONES;
    case (sel_op)
      OP_ROR: rot_amt = '0 - sel_amt;
      OP_SHL: mask    = ONES << sel_amt;
      OP_SHR: begin
        rot_amt = '0 - sel_amt;
        mask    = ONES >> sel_amt;
      end
      default: ;
    endcase
    result = rot_out & mask;
  end

  rotl_core #(
    .DW (DW),
    .AW (AW)
  ) u_rotl_core (
    .data_i (sel_data),
    .amt_i  (rot_amt),
    .data_o (rot_out)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    ptr_d      = ptr_q;
    req_ready  = 2'b00;
    if (accept) begin
      if (any_req) begin
        if (!reset) begin
          req_ready[gnt] = 1'b1;
        end
        state_d    = ST_FULL;
        out_data_d = result;
        out_tag_d  = gnt;
        ptr_d      = ~gnt;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_tag_q  <= 1'b0;
      ptr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed op/arbitration scenarios
// plus a randomized sweep against a behavioural model and result scoreboard.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  shift_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic       m_valid = 1'b0;
  logic       m_tag   = 1'b0;
  logic       m_ptr   = 1'b0;
  logic [7:0] m_data  = 8'h00;

  function automatic logic [7:0] ref_op(logic [7:0] d, logic [2:0] a, logic [1:0] op);
    int x = d;
    int n = a;
    int r;
    case (op)
      2'b00:   r = (x << n) | (x >> (8 - n));
      2'b01:   r = (x >> n) | (x << (8 - n));
      2'b10:   r = x << n;
      default: r = x >> n;
    endcase
    return r[7:0];
  endfunction

  function automatic logic exp_gnt();
    return (bus.req_valid == 2'b11) ? m_ptr : bus.req_valid[1];
  endfunction

  function automatic logic [1:0] exp_ready();
    if (reset) return 2'b00;
    if (m_valid && !bus.out_ready) return 2'b00;
    if (bus.req_valid == 2'b00) return 2'b00;
    return exp_gnt() ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] granted_result(logic g);
    return g ? ref_op(bus.req_data1, bus.req_amt1, bus.req_op1)
             : ref_op(bus.req_data0, bus.req_amt0, bus.req_op0);
  endfunction

  // Advance the model by one edge using the present inputs, then the DUT.
  task automatic cycle();
    logic [1:0] r;
    logic       g;
    r = exp_ready();
    g = exp_gnt();
    if (reset) begin
      m_valid = 1'b0; m_data = 8'h00; m_tag = 1'b0; m_ptr = 1'b0;
    end else if (!m_valid || bus.out_ready) begin
      if (r != 2'b00) begin
        m_data = granted_result(g); m_tag = g; m_valid = 1'b1; m_ptr = ~g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [7:0] d, logic [2:0] a, logic [1:0] o);
    if (i == 0) begin
      bus.req_data0 = d; bus.req_amt0 = a; bus.req_op0 = o;
    end else begin
      bus.req_data1 = d; bus.req_amt1 = a; bus.req_op1 = o;
    end
  endtask

  task automatic set_rand(int i);
    set_req(i, 8'($urandom), 3'($urandom), 2'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.req_valid = 2'b11;
    set_rand(0);
    set_rand(1);
    cycle();
    cycle();
    vectors++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++;
    if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    vectors++;
    if (bus.out_tag !== 1'b0) begin errors++; $display("FAIL reset_out_tag got %b want 0", bus.out_tag); end
    vectors++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    reset = 1'b0;
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_ops();
    logic [1:0] op_t  [11] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
    logic [7:0] dat_t [11] = '{8'hB4, 8'h81, 8'hFF, 8'hFF, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hB4, 8'h81, 8'h81};
    logic [2:0] amt_t [11] = '{3'd3, 3'd1, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd7, 3'd7};
    logic [7:0] exp_t [11] = '{8'hA5, 8'hC0, 8'hF0, 8'h0F, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h96, 8'h01, 8'h80};
    for (int k = 0; k < 11; k++) begin
      set_req(0, dat_t[k], amt_t[k], op_t[k]);
      set_rand(1);
      bus.req_valid = 2'b01;
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL op%0d_req_ready got %b want 01", k, bus.req_ready); end
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_t[k] || bus.out_tag !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_result got v=%b d=%h t=%b want v=1 d=%h t=0", k, bus.out_valid, bus.out_data, bus.out_tag, exp_t[k]);
      end
      bus.req_valid = 2'b00;
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== exp_t[k]) begin
        errors++;
        $display("FAIL op%0d_idle got v=%b d=%h want v=0 d=%h", k, bus.out_valid, bus.out_data, exp_t[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    logic       g;
    do_reset();
    set_rand(0);
    set_rand(1);
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 1);
      #1;
      vectors++;
      if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b%0d_req_ready got %b want %b", k, bus.req_ready, g ? 2'b10 : 2'b01);
      end
      exp_d = g ? ref_op(bus.req_data1, bus.req_amt1, bus.req_op1)
                : ref_op(bus.req_data0, bus.req_amt0, bus.req_op0);
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== g || bus.out_data !== exp_d) begin
        errors++;
        $display("FAIL b2b%0d_result got v=%b t=%b d=%h want v=1 t=%b d=%h", k, bus.out_valid, bus.out_tag, bus.out_data, g, exp_d);
      end
      set_rand(g ? 1 : 0);
    end
    bus.req_valid = 2'b00;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    logic [7:0] exp_d;
    do_reset();
    set_rand(1);
    bus.req_valid = 2'b10;
    bus.out_ready = 1'b1;
    held = ref_op(bus.req_data1, bus.req_amt1, bus.req_op1);
    cycle();
    set_rand(0);
    set_rand(1);
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp%0d_req_ready got %b want 00", k, bus.req_ready); end
      cycle();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_tag !== 1'b1) begin
        errors++;
        $display("FAIL bp%0d_hold got v=%b d=%h t=%b want v=1 d=%h t=1", k, bus.out_valid, bus.out_data, bus.out_tag, held);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready got %b want 01", bus.req_ready); end
    exp_d = ref_op(bus.req_data0, bus.req_amt0, bus.req_op0);
    cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_tag !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain_load got v=%b d=%h t=%b want v=1 d=%h t=0", bus.out_valid, bus.out_data, bus.out_tag, exp_d);
    end
    bus.req_valid = 2'b00;
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d;
    set_rand(0);
    bus.req_valid = 2'b01;
    bus.out_ready = 1'b1;
    cycle();
    set_rand(0);
    set_rand(1);
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rstmid_req_ready got %b want 00", bus.req_ready); end
    cycle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL rstmid_after got v=%b rdy=%b want v=0 rdy=00", bus.out_valid, bus.req_ready);
    end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_tie got %b want 01", bus.req_ready); end
    exp_d = ref_op(bus.req_data0, bus.req_amt0, bus.req_op0);
    cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 1'b0 || bus.out_data !== exp_d) begin
      errors++;
      $display("FAIL rstmid_first got v=%b t=%b d=%h want v=1 t=0 d=%h", bus.out_valid, bus.out_tag, bus.out_data, exp_d);
    end
    bus.req_valid = 2'b00;
    cycle();
  endtask

  task automatic test_random();
    logic [8:0] sb[$];
    logic [8:0] front;
    logic [1:0] hold;
    logic [1:0] r;
    logic       g;
    int         n_in;
    int         n_out;
    hold  = 2'b00;
    n_in  = 0;
    n_out = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          set_rand(i);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      r = exp_ready();
      g = exp_gnt();
      vectors++;
      if (bus.req_ready !== r) begin errors++; $display("FAIL rnd%0d_req_ready got %b want %b", c, bus.req_ready, r); end
      vectors++;
      if (bus.out_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_out_valid got %b want %b", c, bus.out_valid, m_valid); end
      if (m_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rnd%0d_dup_result got d=%h with no pending transfer want none", c, bus.out_data);
        end else begin
          front = sb.pop_front();
          n_out++;
          if ({bus.out_tag, bus.out_data} !== front) begin
            errors++;
            $display("FAIL rnd%0d_result got t=%b d=%h want t=%b d=%h", c, bus.out_tag, bus.out_data, front[8], front[7:0]);
          end
        end
      end
      if (r != 2'b00) begin
        sb.push_back({g, granted_result(g)});
        n_in++;
      end
      hold = bus.req_valid & ~r;
      cycle();
    end
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (m_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL drain%0d_dup_result got d=%h want none", k, bus.out_data);
        end else begin
          front = sb.pop_front();
          n_out++;
          if ({bus.out_tag, bus.out_data} !== front) begin
            errors++;
            $display("FAIL drain%0d_result got t=%b d=%h want t=%b d=%h", k, bus.out_tag, bus.out_data, front[8], front[7:0]);
          end
        end
      end
      cycle();
    end
    vectors++;
    if (sb.size() != 0 || n_in != n_out) begin
      errors++; $display("FAIL rnd_lost got out=%0d pending=%0d want out=%0d pending=0", n_out, sb.size(), n_in);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b0;
    set_req(0, 8'h00, 3'd0, 2'b00);
    set_req(1, 8'h00, 3'd0, 2'b00);
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
